phase_extract_ctrl: RTL and testbench
=====================================

Name: phase_extract_ctrl

Overview:
- Sequencer for the phase-extraction chain: input buffer -> fft -> cartesian-to-polar -> peak detection.
- Replaces the open-loop initial-block resets with a controlled start/reset sequence.
- Counts completed peak-detection frames up to a programmed number of runs, then reports done.
- Supervises the fft and peak_detect packet framing and a stall timeout; flags errors and forces the chain back into reset.

Parameters:
- RUNS, 4, number of peak-detection frames per measurement (>=1).
- RESET_CYCLES, 4, cycles each reset output is held high (>=2, so slower clk20-domain logic sees it).
- TIMEOUT, 65535, maximum cycles allowed between frame ends while running (>=1).
- CNT_WIDTH, 16, width of run_count and the timeout counter (2**CNT_WIDTH > max(RUNS, TIMEOUT)).

Ports:
- clk  in  1  main clock.
- reset  in  1  synchronous, active-high.
- start  in  1  begin measurement; sampled in IDLE, DONE and ERR.
- abort  in  1  stop measurement; sampled in every state except IDLE.
- fft_sop  in  1  fft source_sop.
- fft_eop  in  1  fft source_eop.
- fft_valid  in  1  fft source_valid.
- peak_eop  in  1  peak_detect source_eop.
- peak_valid  in  1  peak_detect source_valid.
- time_reset  out  1  input_buffer reset.
- fft_reset  out  1  fft aclr.
- peak_reset  out  1  peak_detect reset.
- busy  out  1  measurement in progress (RESET or RUN).
- done  out  1  single-cycle pulse: RUNS frames completed.
- run_count  out  CNT_WIDTH  peak frames completed in the current measurement.
- error  out  2  sticky error code: 0 none, 1 framing, 2 timeout.

Behaviour:
- Every output is registered; there is no combinational input-to-output path.
- On reset, the block goes to IDLE:
  - time_reset, fft_reset and peak_reset = 1 (the chain is held in reset);
  - busy, done = 0; run_count, error = 0.
- States: IDLE, RESET, RUN, DONE, ERR.

State IDLE:
- All three resets held at 1.
- start=1 -> RESET; the reset counter is loaded with 0.
- run_count and error are cleared on that transition.

State RESET:
- All three resets = 1; busy = 1; the counter increments every cycle.
- The resets stay high for exactly RESET_CYCLES cycles counted from entry.
- On the last RESET cycle, the next state is RUN. In the first RUN cycle all resets read 0.
- Framing inputs are ignored in RESET.

State RUN:
- Resets = 0; busy = 1.
- in_frame flag:
  - set on fft_valid & fft_sop;
  - cleared on fft_valid & fft_eop;
  - sop and eop in the same cycle form a single-sample frame, so in_frame remains 0.
- Framing error (error=1, next state ERR):
  - fft_valid & fft_sop while in_frame=1 (without a same-cycle eop); or
  - fft_valid & fft_eop while in_frame=0 (without a same-cycle sop).
- Frame count: peak_valid & peak_eop increments run_count.
  - When run_count reaches RUNS, the next state is DONE and done pulses 1 for that cycle.
- Timeout counter:
  - cleared on entry to RUN and on every peak frame end;
  - otherwise increments.
  - When it reaches TIMEOUT: error=2, next state ERR.
- Priority within a cycle (highest first): reset > abort > framing error > completion > timeout.
  - A completing peak_eop in the same cycle as a timeout counts as completion.
- abort=1 -> IDLE; resets = 1 from the next cycle; run_count holds its value; no done pulse.

State DONE:
- Resets held at 1 (chain parked); busy = 0.
- run_count holds RUNS.
- start -> RESET (new measurement); abort -> IDLE.

State ERR:
- Resets = 1; busy = 0; error is held.
- start -> RESET; abort -> IDLE.
- error is cleared only on the transition to RESET or by reset.

Other rules:
- start while busy is ignored.
- Synchronous reset mid-RUN forces the IDLE values in the next cycle, regardless of the other inputs.
- run_count saturates at RUNS and never wraps.

Test Plan:
1. Basic run: RESET_CYCLES=4, RUNS=2, pulse start.
   - Resets stay 1 for 4 cycles, then 0.
   - Drive 2 well-formed fft frames and 2 peak frames: run_count 1 then 2.
   - done pulses exactly once, in the cycle of the 2nd peak_eop; state DONE; resets return to 1; busy = 0.
2. Framing error: in RUN, send a 2nd fft_sop before fft_eop.
   - Next cycle: error=1, resets=1, busy=0.
   - start then clears error and re-runs the 4-cycle reset.
3. Timeout: TIMEOUT=100, enter RUN with no peak_eop.
   - error=2 exactly 100 cycles after RUN entry.
   - Repeat with a peak_eop at cycle 60: the timeout fires 100 cycles after that eop instead.
4. Abort and restart: abort after 1 of 2 peak frames.
   - IDLE, run_count=1, no done pulse.
   - start clears run_count to 0 and restarts.
5. Edge cases:
   - A single-cycle fft frame (sop=eop=1) raises no error.
   - start asserted in RUN has no effect.
   - Synchronous reset asserted together with peak_eop on the final frame: no done pulse, all outputs at their IDLE values next cycle.
6. Same-cycle priority: TIMEOUT reached in the same cycle as the final peak_eop.
   - done=1, error=0, state DONE.

Source files
------------

// File: rtl/phase_extract_ctrl_if.sv
// Status/framing signals from the phase-extraction chain (fft and peak_detect sources).
// The chain drives them through the master modport; the controller observes them through the slave modport.
interface phase_extract_ctrl_if;
    logic fft_sop;
    logic fft_eop;
    logic fft_valid;
    logic peak_eop;
    logic peak_valid;

    modport master (
        output fft_sop,
        output fft_eop,
        output fft_valid,
        output peak_eop,
        output peak_valid
    );

    modport slave (
        input fft_sop,
        input fft_eop,
        input fft_valid,
        input peak_eop,
        input peak_valid
    );
endinterface

// File: rtl/phase_extract_ctrl.sv
// Start/reset sequencer for the input buffer -> fft -> cart2polar -> peak detection chain.
// It counts peak frames up to RUNS and supervises fft packet framing and stall timeouts.
module phase_extract_ctrl #(
    parameter int unsigned RUNS         = 4,
    parameter int unsigned RESET_CYCLES = 4,
    parameter int unsigned TIMEOUT      = 65535,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    phase_extract_ctrl_if.slave  chain,
    output logic                 time_reset,
    output logic                 fft_reset,
    output logic                 peak_reset,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] run_count,
    output logic [1:0]           error
);

    localparam logic [CNT_WIDTH-1:0] RstLast  = CNT_WIDTH'(RESET_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TmoLast  = CNT_WIDTH'(TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] RunsVal  = CNT_WIDTH'(RUNS);
    localparam logic [CNT_WIDTH-1:0] RunsLast = CNT_WIDTH'(RUNS - 1);

    localparam logic [1:0] ErrNone    = 2'd0;
    localparam logic [1:0] ErrFraming = 2'd1;
    localparam logic [1:0] ErrTimeout = 2'd2;

    typedef enum logic [2:0] {
        StIdle,
        StReset,
        StRun,
        StDone,
        StErr
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] run_count_q, run_count_d;
    logic [1:0]           error_q, error_d;
    logic                 in_frame_q, in_frame_d;
    logic                 done_q, done_d;
    logic                 chain_rst_q;
    logic                 busy_q;

    logic sop_hit, eop_hit, peak_end, frame_err;

    assign sop_hit  = chain.fft_valid & chain.fft_sop;
    assign eop_hit  = chain.fft_valid & chain.fft_eop;
    assign peak_end = chain.peak_valid & chain.peak_eop;
    // A same-cycle sop+eop is a complete single-sample frame, never a framing fault.
    assign frame_err = (sop_hit & ~eop_hit & in_frame_q) | (eop_hit & ~sop_hit & ~in_frame_q);

    // cnt_q counts reset cycles in StReset and idle cycles since the last frame end in StRun.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        run_count_d = run_count_q;
        error_d     = error_q;
        in_frame_d  = 1'b0;
        done_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StReset;
                    cnt_d       = '0;
                    run_count_d = '0;
                    error_d     = ErrNone;
                end
            end
            StReset: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (cnt_q == RstLast) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRun: begin
                in_frame_d = in_frame_q;
                if (sop_hit) in_frame_d = 1'b1;
                if (eop_hit) in_frame_d = 1'b0;

                if (abort) begin
                    state_d = StIdle;
                end else if (frame_err) begin
                    state_d = StErr;
                    error_d = ErrFraming;
                end else if (peak_end) begin
                    cnt_d = '0;
                    if (run_count_q < RunsVal) run_count_d = run_count_q + 1'b1;
                    if (run_count_q == RunsLast) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end
                end else if (cnt_q == TmoLast) begin
                    state_d = StErr;
                    error_d = ErrTimeout;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone, StErr: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (start) begin
                    state_d     = StReset;
                    cnt_d       = '0;
                    run_count_d = '0;
                    error_d     = ErrNone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they track the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            run_count_q <= '0;
            error_q     <= ErrNone;
            in_frame_q  <= 1'b0;
            done_q      <= 1'b0;
            chain_rst_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            run_count_q <= run_count_d;
            error_q     <= error_d;
            in_frame_q  <= in_frame_d;
            done_q      <= done_d;
            chain_rst_q <= (state_d != StRun);
            busy_q      <= (state_d == StReset) || (state_d == StRun);
        end
    end

    assign time_reset = chain_rst_q;
    assign fft_reset  = chain_rst_q;
    assign peak_reset = chain_rst_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign run_count  = run_count_q;
    assign error      = error_q;

endmodule

// File: tb/tb_phase_extract_ctrl.sv
// Directed bench for phase_extract_ctrl: RUNS=2, RESET_CYCLES=4, TIMEOUT=100.
// Inputs change 1 ns after a rising edge; outputs are read at the same point.
module tb_phase_extract_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        time_reset, fft_reset, peak_reset, busy, done;
    logic [15:0] run_count;
    logic [1:0]  error;

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;

    always #5 clk = ~clk;

    phase_extract_ctrl_if chain_if ();

    phase_extract_ctrl #(
        .RUNS         (2),
        .RESET_CYCLES (4),
        .TIMEOUT      (100),
        .CNT_WIDTH    (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .chain      (chain_if.slave),
        .time_reset (time_reset),
        .fft_reset  (fft_reset),
        .peak_reset (peak_reset),
        .busy       (busy),
        .done       (done),
        .run_count  (run_count),
        .error      (error)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rsts();
        return 32'({time_reset, fft_reset, peak_reset});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_chain();
        chain_if.fft_sop    = 1'b0;
        chain_if.fft_eop    = 1'b0;
        chain_if.fft_valid  = 1'b0;
        chain_if.peak_eop   = 1'b0;
        chain_if.peak_valid = 1'b0;
    endtask

    // Pulse start, check the 4-cycle reset window, and stop at the first RUN cycle.
    task automatic enter_run(input string tag);
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq({tag, " error cleared"}, 32'(error), 0);
        check_eq({tag, " run_count cleared"}, 32'(run_count), 0);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("%s reset cycle %0d", tag, i), rsts(), 7);
            check_eq($sformatf("%s busy cycle %0d", tag, i), 32'(busy), 1);
            step();
        end
        check_eq({tag, " resets released"}, rsts(), 0);
        check_eq({tag, " busy in run"}, 32'(busy), 1);
    endtask

    task automatic fft_frame(input int len);
        for (int i = 0; i < len; i++) begin
            chain_if.fft_valid = 1'b1;
            chain_if.fft_sop   = (i == 0);
            chain_if.fft_eop   = (i == len - 1);
            step();
        end
        clear_chain();
    endtask

    task automatic peak_pulse();
        chain_if.peak_valid = 1'b1;
        chain_if.peak_eop   = 1'b1;
        step();
        clear_chain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_chain();

        // Reset values
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("rst resets", rsts(), 7);
        check_eq("rst busy", 32'(busy), 0);
        check_eq("rst done", 32'(done), 0);
        check_eq("rst run_count", 32'(run_count), 0);
        check_eq("rst error", 32'(error), 0);

        // 1. Basic run of two frames
        enter_run("t1");
        fft_frame(4);
        fft_frame(3);
        check_eq("t1 no frame error", 32'(error), 0);
        peak_pulse();
        check_eq("t1 run_count 1", 32'(run_count), 1);
        check_eq("t1 no early done", 32'(done), 0);
        fft_frame(2);
        peak_pulse();
        check_eq("t1 run_count 2", 32'(run_count), 2);
        check_eq("t1 done pulse", 32'(done), 1);
        check_eq("t1 resets parked", rsts(), 7);
        check_eq("t1 busy low", 32'(busy), 0);
        step();
        check_eq("t1 done single", 32'(done), 0);
        check_eq("t1 run_count held", 32'(run_count), 2);

        // 2. Second sop inside a frame
        enter_run("t2");
        chain_if.fft_valid = 1'b1;
        chain_if.fft_sop   = 1'b1;
        step();
        check_eq("t2 first sop ok", 32'(error), 0);
        step();
        clear_chain();
        check_eq("t2 framing error", 32'(error), 1);
        check_eq("t2 resets", rsts(), 7);
        check_eq("t2 busy", 32'(busy), 0);
        step();
        check_eq("t2 error sticky", 32'(error), 1);
        enter_run("t2 restart");

        // 3. Timeout 100 cycles after RUN entry
        repeat (99) step();
        check_eq("t3 no early timeout", 32'(error), 0);
        step();
        check_eq("t3 timeout", 32'(error), 2);
        check_eq("t3 busy", 32'(busy), 0);
        check_eq("t3 resets", rsts(), 7);

        // Peak eop in RUN cycle 60 restarts the 100-cycle window from the edge that samples it
        enter_run("t3b");
        repeat (60) step();
        peak_pulse();
        check_eq("t3b run_count 1", 32'(run_count), 1);
        repeat (99) step();
        check_eq("t3b no early timeout", 32'(error), 0);
        step();
        check_eq("t3b timeout", 32'(error), 2);
        check_eq("t3b run_count held", 32'(run_count), 1);

        // 4. Abort after one of two frames
        enter_run("t4");
        fft_frame(3);
        peak_pulse();
        check_eq("t4 run_count 1", 32'(run_count), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_eq("t4 resets", rsts(), 7);
        check_eq("t4 busy", 32'(busy), 0);
        check_eq("t4 no done", 32'(done), 0);
        check_eq("t4 run_count held", 32'(run_count), 1);
        step();
        check_eq("t4 still no done", 32'(done), 0);
        check_eq("t4 idle busy", 32'(busy), 0);

        // 5. Edge cases
        enter_run("t5");
        fft_frame(1);
        check_eq("t5 single-sample frame", 32'(error), 0);
        fft_frame(2);
        check_eq("t5 frame after single", 32'(error), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("t5 start in run busy", 32'(busy), 1);
        check_eq("t5 start in run resets", rsts(), 0);
        step();
        check_eq("t5 start ignored", rsts(), 0);
        peak_pulse();
        check_eq("t5 run_count 1", 32'(run_count), 1);
        reset = 1'b1;
        chain_if.peak_valid = 1'b1;
        chain_if.peak_eop   = 1'b1;
        step();
        reset = 1'b0;
        clear_chain();
        check_eq("t5 reset beats done", 32'(done), 0);
        check_eq("t5 reset run_count", 32'(run_count), 0);
        check_eq("t5 reset resets", rsts(), 7);
        check_eq("t5 reset busy", 32'(busy), 0);
        check_eq("t5 reset error", 32'(error), 0);

        // 6. Final peak eop on the same cycle the timeout would fire
        enter_run("t6");
        repeat (10) step();
        peak_pulse();
        check_eq("t6 run_count 1", 32'(run_count), 1);
        repeat (99) step();
        check_eq("t6 no early timeout", 32'(error), 0);
        peak_pulse();
        check_eq("t6 done wins", 32'(done), 1);
        check_eq("t6 no timeout error", 32'(error), 0);
        check_eq("t6 run_count 2", 32'(run_count), 2);
        check_eq("t6 parked", rsts(), 7);
        check_eq("t6 busy", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
